// File: rtl/bus_pkg.sv
// Shared bus definitions: destination field layout, broadcast
// address and receive FIFO state encoding.
package bus_pkg;

  localparam int DEST_W = 8;
  localparam logic [DEST_W-1:0] BCAST_ADDR = 8'hFF;
  localparam int PKT_MAX = 256;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } rx_state_t;

  // Destination is the top DEST_W bits of a w-bit packet.
  function automatic logic [DEST_W-1:0] dest_of(
    input logic [PKT_MAX-1:0] pkt,
    input int unsigned        w
  );
    return DEST_W'(pkt >> (w - DEST_W));
  endfunction

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO with explicit count and a
// three-state occupancy FSM driving registered flags.
module fwft_fifo
  import bus_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_i,
  input  logic [pckg_sz-1:0]         wdata_i,
  input  logic                       rd_i,
  output logic [pckg_sz-1:0]         rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [pckg_sz-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  rx_state_t          st_q;
  rx_state_t          st_d;
  logic               do_rd;
  logic               do_wr;

  assign do_rd = rd_i && (st_q != EMPTY);
  assign do_wr = wr_i && ((st_q != FULL) || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      st_q   <= EMPTY;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      EMPTY: begin
        if (do_wr) st_d = PARTIAL;
      end
      PARTIAL: begin
        if (do_rd && !do_wr && cnt_q == CW'(1))
          st_d = EMPTY;
        else if (do_wr && !do_rd && cnt_q == CW'(DEPTH-1))
          st_d = FULL;
      end
      FULL: begin
        if (do_rd && !do_wr) st_d = PARTIAL;
      end
      default: st_d = EMPTY;
    endcase
  end

  assign valid_o = (st_q != EMPTY);
  assign full_o  = (st_q == FULL);
  assign count_o = cnt_q;
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/bus_rx_endpoint.sv
// Device-side bus receiver: filters beats by destination, queues
// them in a FWFT FIFO and counts packets dropped on overflow.
module bus_rx_endpoint
  import bus_pkg::*;
#(
  parameter int               drvrs   = 4,
  parameter int               pckg_sz = 16,
  parameter int               DEPTH   = 8,
  parameter int               ID      = 0,
  parameter logic [DEST_W-1:0] BCAST  = BCAST_ADDR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic [7:0]                 ovf_cnt,
  output logic                       ovf_flag,
  input  logic                       clr_ovf
);

  logic [DEST_W-1:0] dest;
  logic              match;
  logic              wr_ok;
  logic              drop;
  logic [7:0]        ovf_cnt_q;
  logic [7:0]        ovf_cnt_d;
  logic              ovf_flag_q;
  logic              ovf_flag_d;

  assign dest  = dest_of(PKT_MAX'(D_push), pckg_sz);
  assign match = push && (dest == DEST_W'(ID) || dest == BCAST);
  // A read in the same cycle frees a slot, so full alone is not a drop.
  assign wr_ok = match && (!full || rd_en);
  assign drop  = match && full && !rd_en;

  fwft_fifo #(
    .pckg_sz (pckg_sz),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_i    (wr_ok),
    .wdata_i (D_push),
    .rd_i    (rd_en),
    .rdata_o (rd_data),
    .valid_o (rd_valid),
    .full_o  (full),
    .count_o (count)
  );

  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (drop) begin
      ovf_flag_d = 1'b1;
      if (clr_ovf)
        ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != 8'hFF)
        ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      ovf_cnt_d  = '0;
      ovf_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_q  <= '0;
      ovf_flag_q <= 1'b0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  assign ovf_cnt  = ovf_cnt_q;
  assign ovf_flag = ovf_flag_q;

endmodule

// File: doc/bus_rx_endpoint.md
Name: bus_rx_endpoint

Overview:
- Device-side receive end of the bus generator/arbiter push interface.
- Sits on one device port of the bus and samples every `push`/`D_push` beat the bus broadcasts.
- Keeps only packets addressed to its own ID (or broadcast) in a first-word-fall-through FIFO; the device drains them through a simple read port.
- Counts packets dropped on overflow.

Parameters:
- drvrs, 4, number of devices on the bus; ID must be < drvrs.
- pckg_sz, 16, packet width in bits; must be >= 16.
- DEPTH, 8, receive FIFO depth in words; power of two, >= 2.
- ID, 0, this endpoint's destination address.
- BCAST, 8'hFF, broadcast destination address.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  bus strobe; D_push valid this cycle.
- D_push  in  pckg_sz  packet; [pckg_sz-1:pckg_sz-8] = destination, rest = payload.
- rd_en  in  1  device pops the head word.
- rd_data  out  pckg_sz  head word (full packet, header included); 0 when empty.
- rd_valid  out  1  FIFO non-empty.
- count  out  $clog2(DEPTH+1)  words held.
- full  out  1  count == DEPTH.
- ovf_cnt  out  8  dropped-packet count, saturating at 255.
- ovf_flag  out  1  sticky: at least one drop since the last clear.
- clr_ovf  in  1  clears ovf_cnt and ovf_flag.

Behaviour:
- Reset: one clock; asynchronous, active-low. While reset == 0: pointers = 0, count = 0, rd_valid = 0, full = 0, rd_data = 0, ovf_cnt = 0, ovf_flag = 0, FSM = EMPTY. Asserting reset mid-operation discards all stored words immediately.
- Match: dest = D_push[pckg_sz-1 -: 8]. A beat matches when push == 1 and (dest == ID or dest == BCAST). Non-matching beats are ignored and never counted as drops.
- Write: a matching beat is written at the clock edge when not full, or when full with rd_en == 1 in the same cycle. Latency is 1 cycle: the word is visible on rd_data/rd_valid after that edge if the FIFO was empty.
- Read: rd_data is combinational from the head entry (first-word fall-through). rd_en with rd_valid == 1 advances the head at the edge. rd_en while empty is ignored: no pointer move, no underflow.
- Simultaneous write and read:
  - Non-empty, non-full: both occur; count unchanged.
  - Empty: the write occurs, the read is ignored.
  - Full: both occur; count stays DEPTH.
- Overflow: a matching beat while full and rd_en == 0 is dropped. ovf_flag <= 1; ovf_cnt increments unless it is already 255.
- clr_ovf: when asserted, ovf_cnt <= 0 and ovf_flag <= 0. If a drop occurs in the same cycle, the result is ovf_cnt = 1 and ovf_flag = 1.
- Pointers: $clog2(DEPTH)-bit read/write pointers that wrap modulo DEPTH. count is tracked separately, not derived from the pointers.
- FSM states: EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on a write.
  - PARTIAL -> EMPTY on a read with count == 1 and no write.
  - PARTIAL -> FULL on a write with count == DEPTH-1 and no read.
  - FULL -> PARTIAL on a read without a write.
  - All other cases hold state.
- Flag encoding: rd_valid = (state != EMPTY), full = (state == FULL). Both are registered, so there is no combinational path from push or rd_en to these flags.

Decomposition:
- Package bus_pkg:
  - constants DEST_W = 8 and BCAST_ADDR = 8'hFF;
  - function dest_of(pkt) that extracts the destination field;
  - typedef enum rx_state_t {EMPTY, PARTIAL, FULL}.
- Sub-module fwft_fifo (parameters pckg_sz and DEPTH) holds the storage, pointers, count and FSM.
- bus_rx_endpoint contains the address match, drop logic and overflow counter.

Test Plan:
- After reset, 3 beats with ID=2, dest 0x02, payloads 0x11/0x22/0x33 -> count = 3; rd_data sequence reads back 0x0211, 0x0222, 0x0233; rd_valid drops to 0 after the 3rd rd_en.
- Beats with dest 0x01, 0x03 and 0xFF at ID=2 -> only the 0xFF packet is stored; count = 1; ovf_cnt = 0.
- DEPTH=8: 10 matching beats with no reads -> full = 1; ovf_cnt = 2; ovf_flag = 1; the head is the 1st packet; a beat arriving with rd_en while full is accepted and count stays 8.
- 300 matching beats with the FIFO held full -> ovf_cnt saturates at 255; clr_ovf in the same cycle as a drop -> ovf_cnt = 1, ovf_flag = 1.
- Fill to 5 words, pulse reset low mid-stream for 1 cycle -> count = 0, rd_valid = 0 and rd_data = 0 immediately; the next beat is read back as the first word.
- rd_en held high while empty for 4 cycles, then one write -> no underflow; the word appears on rd_data one cycle later and pops on the next edge; 20 write/read interleaves across pointer wrap return the data in order.
